// File: rtl/matrix_keypad_scan.sv
// 4x4 matrix keypad scanner: walks one active-low column at a time, debounces each key, and pulses on each debounced press.
// Latency: press-to-pulse at most DB_CNT*4*SCAN_DIV + 2 clk from a stable row level (2-flop sync plus one sample per column slot).
// Backpressure: none; key_pulse is a one-cycle strobe that must be consumed when it is asserted.
// Ports: clk, rst_n (async, active-low); row[3:0] in (active-low, async);
//        col[3:0] out (one bit low); key_pulse/key_state[15:0] out; key_valid, key_code[3:0] out.
module matrix_keypad_scan #(
  parameter int SCAN_DIV = 12000,
  parameter int DB_CNT   = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [15:0] key_pulse,
  output logic [15:0] key_state,
  output logic        key_valid,
  output logic [3:0]  key_code
);

  logic [3:0]  row_s1, row_s2;
  logic [15:0] slot_cnt;
  logic [1:0]  col_idx;
  logic [1:0]  col_idx_nxt;
  logic        sample_edge;
  logic [2:0]  cnt     [16];
  logic [2:0]  cnt_nxt [16];
  logic [15:0] state_nxt;
  logic [15:0] rise;

  function automatic logic [3:0] lowest_idx(input logic [15:0] v);
    lowest_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) lowest_idx = 4'(i);
    end
  endfunction

  assign sample_edge = (slot_cnt == 16'(SCAN_DIV - 1));
  assign col_idx_nxt = sample_edge ? col_idx + 2'd1 : col_idx;

  // Per-key agreement counters; only the column being sampled moves.
  always_comb begin
    state_nxt = key_state;
    for (int k = 0; k < 16; k++) begin
      cnt_nxt[k] = cnt[k];
      if (sample_edge && (col_idx == 2'(k))) begin
        // A pressed key pulls its row low, so the sample is the inverted row.
        if (!row_s2[k / 4] == key_state[k]) begin
          cnt_nxt[k] = 3'd0;
        end else if (cnt[k] == 3'(DB_CNT - 1)) begin
          state_nxt[k] = ~key_state[k];
          cnt_nxt[k]   = 3'd0;
        end else begin
          cnt_nxt[k] = cnt[k] + 3'd1;
        end
      end
    end
  end

  assign rise = state_nxt & ~key_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_s1    <= 4'd0;
      row_s2    <= 4'd0;
      slot_cnt  <= 16'd0;
      col_idx   <= 2'd0;
      col       <= 4'b1110;
      key_state <= 16'd0;
      key_pulse <= 16'd0;
      key_valid <= 1'b0;
      key_code  <= 4'd0;
      for (int k = 0; k < 16; k++) cnt[k] <= 3'd0;
    end else begin
      row_s1    <= row;
      row_s2    <= row_s1;
      slot_cnt  <= sample_edge ? 16'd0 : slot_cnt + 16'd1;
      col_idx   <= col_idx_nxt;
      // Driven from the next index so col always matches the index it sits beside.
      col       <= ~(4'b0001 << col_idx_nxt);
      key_state <= state_nxt;
      key_pulse <= rise;
      key_valid <= |rise;
      if (|rise) key_code <= lowest_idx(rise);
      for (int k = 0; k < 16; k++) cnt[k] <= cnt_nxt[k];
    end
  end

endmodule

// File: tb/tb_matrix_keypad_scan.sv
module tb_matrix_keypad_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [15:0] key_pulse;
  logic [15:0] key_state;
  logic        key_valid;
  logic [3:0]  key_code;

  logic [15:0] held = 16'd0;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_pulse_cyc = 0;
  logic [3:0] code_hold = 4'd0;

  typedef struct {
    logic [15:0] pulse;
    logic [3:0]  code;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [15:0] held;
    int          frames;
    logic [15:0] pulse1;
    logic [3:0]  code1;
    logic [15:0] pulse2;
    logic [3:0]  code2;
    logic [15:0] state;
  } vec_t;

  matrix_keypad_scan #(.SCAN_DIV(4), .DB_CNT(3)) dut (
    .clk(clk), .rst_n(rst_n), .row(row), .col(col),
    .key_pulse(key_pulse), .key_state(key_state),
    .key_valid(key_valid), .key_code(key_code)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Keypad model: a held key shorts its column to its row.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (held[4*r+c] && !col[c]) row[r] = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Output monitor: every pulse must match the next scoreboard entry.
  always @(negedge clk) begin
    if (rst_n) begin
      exp_t e;
      chk("valid_vs_pulse", {31'd0, key_valid}, {31'd0, key_pulse != 16'd0});
      if (key_pulse != 16'd0) begin
        last_pulse_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", {16'd0, key_pulse}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("pulse", {16'd0, key_pulse}, {16'd0, e.pulse});
          chk("code", {28'd0, key_code}, {28'd0, e.code});
          code_hold = e.code;
        end
      end else begin
        chk("code_hold", {28'd0, key_code}, {28'd0, code_hold});
      end
    end
  end

  task automatic push(input logic [15:0] p, input logic [3:0] c);
    exp_t e;
    e.pulse = p;
    e.code  = c;
    exp_q.push_back(e);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leave the bench at the negedge just after col0 becomes driven.
  task automatic align();
    int n = 0;
    while (col != 4'b0111 && n < 64) begin @(negedge clk); n++; end
    while (col != 4'b1110 && n < 64) begin @(negedge clk); n++; end
    if (n >= 64) begin
      total++;
      bad++;
      $display("FAIL align_timeout actual=%0h required=%0h", col, 4'b1110);
    end
  endtask

  task automatic chk_queue_empty(input string name);
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  vec_t vecs [6];
  int   rel_cyc;

  initial begin
    vecs[0] = '{16'h0020, 10, 16'h0020, 4'd5,  16'h0000, 4'd0,  16'h0020};
    vecs[1] = '{16'h0000, 4,  16'h0000, 4'd0,  16'h0000, 4'd0,  16'h0000};
    vecs[2] = '{16'h0044, 4,  16'h0044, 4'd2,  16'h0000, 4'd0,  16'h0044};
    vecs[3] = '{16'h0000, 4,  16'h0000, 4'd0,  16'h0000, 4'd0,  16'h0000};
    vecs[4] = '{16'h8001, 4,  16'h0001, 4'd0,  16'h8000, 4'd15, 16'h8001};
    vecs[5] = '{16'h0000, 4,  16'h0000, 4'd0,  16'h0000, 4'd0,  16'h0000};

    // Reset state
    rst_n = 1'b0;
    wait_cycles(3);
    chk("rst_col", {28'd0, col}, {28'd0, 4'b1110});
    chk("rst_pulse", {16'd0, key_pulse}, 32'd0);
    chk("rst_state", {16'd0, key_state}, 32'd0);
    chk("rst_valid", {31'd0, key_valid}, 32'd0);
    chk("rst_code", {28'd0, key_code}, 32'd0);
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 1 || k == 3 || k == 16) chk("col_step_c0", {28'd0, col}, {28'd0, 4'b1110});
      if (k == 4)  chk("col_step_c1", {28'd0, col}, {28'd0, 4'b1101});
      if (k == 8)  chk("col_step_c2", {28'd0, col}, {28'd0, 4'b1011});
      if (k == 12) chk("col_step_c3", {28'd0, col}, {28'd0, 4'b0111});
    end
    chk("idle_state", {16'd0, key_state}, 32'd0);

    // Table-driven press/release vectors
    for (int i = 0; i < 6; i++) begin
      align();
      held = vecs[i].held;
      if (vecs[i].pulse1 != 16'd0) push(vecs[i].pulse1, vecs[i].code1);
      if (vecs[i].pulse2 != 16'd0) push(vecs[i].pulse2, vecs[i].code2);
      wait_cycles(vecs[i].frames * 16);
      chk($sformatf("vec%0d_state", i), {16'd0, key_state}, {16'd0, vecs[i].state});
      chk_queue_empty($sformatf("vec%0d_missing_pulse", i));
    end

    // Bounce: two agreeing samples then release
    align();
    held = 16'h0020;
    wait_cycles(32);
    held = 16'h0000;
    wait_cycles(64);
    chk("bounce_state", {16'd0, key_state}, 32'd0);

    // Reset while key 5 is debounced and still held
    align();
    held = 16'h0020;
    push(16'h0020, 4'd5);
    wait_cycles(64);
    chk("pre_rst_state", {16'd0, key_state}, {16'd0, 16'h0020});
    chk_queue_empty("pre_rst_missing_pulse");
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_state", {16'd0, key_state}, 32'd0);
    chk("midrst_code", {28'd0, key_code}, 32'd0);
    chk("midrst_col", {28'd0, col}, {28'd0, 4'b1110});
    code_hold = 4'd0;
    wait_cycles(2);
    rst_n = 1'b1;
    rel_cyc = cyc;
    push(16'h0020, 4'd5);
    wait_cycles(64);
    chk("post_rst_state", {16'd0, key_state}, {16'd0, 16'h0020});
    chk("post_rst_latency", last_pulse_cyc - rel_cyc, 40);
    chk_queue_empty("post_rst_missing_pulse");
    held = 16'h0000;
    wait_cycles(64);
    chk("final_release_state", {16'd0, key_state}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
